// File: rtl/reset_sequencer_if.sv
// Lock/request inputs and reset/status outputs of reset_sequencer, grouped for
// top-level wiring. The master drives lock/request; the slave is the sequencer.
interface reset_sequencer_if #(
  parameter int NUM_CH = 3
);
  logic              iLOCK;
  logic              iREQ;
  logic [NUM_CH-1:0] oRST;
  logic              oDONE;
  logic              oBUSY;

  modport master (output iLOCK, output iREQ, input oRST, input oDONE, input oBUSY);
  modport slave  (input iLOCK, input iREQ, output oRST, output oDONE, output oBUSY);
endinterface

// File: rtl/reset_sequencer.sv
// Staggered active-low reset releases (channel k at FIRST + k*STEP) gated on a filtered lock.
// Define RST_SHUTDOWN_SEQ_EN for a reverse-order, SD_STEP-spaced shutdown on soft request.
module reset_sequencer #(
  parameter int               NUM_CH    = 3,
  parameter int               CNT_W     = 22,
  parameter logic [CNT_W-1:0] FIRST     = 22'h1FFFFF,
  parameter logic [CNT_W-1:0] STEP      = 22'h100000,
  parameter int               LOCK_FILT = 4,
  parameter int               SD_STEP   = 16
) (
  input logic              iCLK,
  input logic              iRST,
  reset_sequencer_if.slave bus
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [63:0] T_LAST_W = 64'(FIRST) + 64'(NUM_CH - 1) * 64'(STEP);

  generate
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("reset_sequencer: NUM_CH must be in 1..8");
    end
    if (LOCK_FILT < 1 || SD_STEP < 1) begin : g_bad_filt
      $error("reset_sequencer: LOCK_FILT and SD_STEP must be >= 1");
    end
    if (T_LAST_W >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
      $error("reset_sequencer: last release count does not fit in CNT_W bits");
    end
  endgenerate

  function automatic logic [CNT_W-1:0] t_of(input int k);
    return CNT_W'(64'(FIRST) + 64'(k) * 64'(STEP));
  endfunction

  localparam logic [CNT_W-1:0] T_LAST = t_of(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_COUNT    = 2'd1,
    S_DONE     = 2'd2
`ifdef RST_SHUTDOWN_SEQ_EN
    , S_SHUTDOWN = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cont_q, cont_d, cont_inc;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic              lock_ok;

`ifdef RST_SHUTDOWN_SEQ_EN
  localparam int SW = (SD_STEP > 1) ? $clog2(SD_STEP) : 1;
  logic [SW-1:0] sd_q, sd_d;
`endif

  assign lock_ok  = (filt_q == FW'(LOCK_FILT));
  assign cont_inc = (cont_q >= T_LAST) ? cont_q : cont_q + 1'b1;

  always_comb begin
    filt_d = filt_q;
    if (!bus.iLOCK) begin
      filt_d = '0;
    end else if (filt_q != FW'(LOCK_FILT)) begin
      filt_d = filt_q + 1'b1;
    end else begin
      filt_d = filt_q;
    end
  end

  // Lock loss outranks a soft request; a request in COUNT restarts from zero.
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    rst_d   = rst_q;
    done_d  = done_q;
    busy_d  = busy_q;
`ifdef RST_SHUTDOWN_SEQ_EN
    sd_d    = sd_q;
`endif
    case (state_q)
      S_HOLD: begin
        cont_d = '0;
        rst_d  = '0;
        done_d = 1'b0;
        if (lock_ok) begin
          state_d = S_COUNT;
          busy_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
          busy_d  = 1'b0;
        end
      end
      S_COUNT: begin
        if (!lock_ok) begin
          state_d = S_HOLD;
          cont_d  = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (bus.iREQ) begin
          cont_d = '0;
          rst_d  = '0;
        end else begin
          cont_d = cont_inc;
          for (int k = 0; k < NUM_CH; k++) begin
            rst_d[k] = rst_q[k] | (cont_inc >= t_of(k));
          end
          if (&rst_d) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_DONE: begin
        if (!lock_ok) begin
          state_d = S_HOLD;
          cont_d  = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (bus.iREQ) begin
`ifdef RST_SHUTDOWN_SEQ_EN
          state_d = S_SHUTDOWN;
          rst_d   = rst_q >> 1;
          sd_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
`else
          state_d = S_HOLD;
          cont_d  = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef RST_SHUTDOWN_SEQ_EN
      // Released channels always form a low-order run, so a right shift asserts the top one.
      S_SHUTDOWN: begin
        if (!lock_ok || rst_q == '0) begin
          state_d = S_HOLD;
          cont_d  = '0;
          rst_d   = '0;
          busy_d  = 1'b0;
        end else if (sd_q == SW'(SD_STEP - 1)) begin
          rst_d = rst_q >> 1;
          sd_d  = '0;
        end else begin
          sd_d = sd_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_HOLD;
        cont_d  = '0;
        rst_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_HOLD;
      cont_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      filt_q  <= '0;
`ifdef RST_SHUTDOWN_SEQ_EN
      sd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      filt_q  <= filt_d;
`ifdef RST_SHUTDOWN_SEQ_EN
      sd_q    <= sd_d;
`endif
    end
  end

  assign bus.oRST  = rst_q;
  assign bus.oDONE = done_q;
  assign bus.oBUSY = busy_q;

endmodule
